reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 138 +++++++++++++
 tb/tb_reg_file_sb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register busy scoreboard.
// After reset it runs an INIT sweep that clears registers 1..DEPTH-1, one per
// cycle. It then enters RUN, where it accepts writes and claims.
// Register 0 is hardwired to zero and is never busy.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and a cleared busy flag) to a read port whose index matches wr_addr.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ready                1 while in RUN (initialisation done)
//   rd_addr1/2           read indices
//   rd_data1/2           combinational read data (0 during INIT)
//   rd_busy1/2           combinational busy flag of the addressed register
//   we/wr_addr/wr_data   write port; a write clears the busy bit
//   claim_en/claim_addr  marks a register busy; a claim wins over a same-cycle write
module reg_file_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              ready,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              claim_en,
   input  logic [ADDR_W-1:0] claim_addr
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } fsmState_t;

   fsmState_t         state;
   fsmState_t         nextState;
   logic [ADDR_W-1:0] clrCnt;
   logic [DEPTH-1:0]  busy;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              running;
   logic              wrHit;
   logic              claimHit;

   assign running  = (state == RUN);
   assign ready    = running;
   assign wrHit    = running && we && (wr_addr != '0);
   assign claimHit = running && claim_en && (claim_addr != '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
      end else begin
         state <= nextState;
      end
   end

   // Next state: leave INIT once the last register has been cleared
   always_comb begin
      nextState = state;
      case (state)
         INIT:    if (clrCnt == LAST_IDX) nextState = RUN;
         RUN:     nextState = RUN;
         default: nextState = INIT;
      endcase
   end

   // Clear counter: starts at 1 because register 0 needs no storage clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clrCnt <= ADDR_W'(1);
      end else if ((state == INIT) && (clrCnt != LAST_IDX)) begin
         clrCnt <= clrCnt + ADDR_W'(1);
      end
   end

   // Storage: not reset; the INIT sweep zeroes it instead
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[clrCnt] <= '0;
      end else if (wrHit) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Scoreboard: the claim is applied last so that it wins over a same-index write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (wrHit) begin
            busy[wr_addr] <= 1'b0;
         end
         if (claimHit) begin
            busy[claim_addr] <= 1'b1;
         end
      end
   end

   // Read ports: zero during INIT and for index 0; optional write bypass
   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      rd_busy1 = 1'b0;
      rd_busy2 = 1'b0;
      if (running) begin
         if (rd_addr1 != '0) begin
            rd_data1 = mem[rd_addr1];
            rd_busy1 = busy[rd_addr1];
         end
         if (rd_addr2 != '0) begin
            rd_data2 = mem[rd_addr2];
            rd_busy2 = busy[rd_addr2];
         end
`ifdef REGFILE_BYPASS_EN
         if (wrHit && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;
         end
         if (wrHit && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ready;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;
   logic        rd_busy1;
   logic        rd_busy2;
   logic        we;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        claim_en;
   logic [4:0]  claim_addr;

   int checks = 0;
   int errors = 0;
   int n;

   reg_file_sb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready      (ready),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .rd_data1   (rd_data1),
      .rd_data2   (rd_data2),
      .rd_busy1   (rd_busy1),
      .rd_busy2   (rd_busy2),
      .we         (we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .claim_en   (claim_en),
      .claim_addr (claim_addr)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Count edges until ready (bounded); optionally drive writes/claims throughout
   task automatic waitReady(input bit junk, output int cnt);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin
         if (junk) begin
            we         = 1'b1;
            wr_addr    = 5'(cnt % 31 + 1);
            wr_data    = 32'hFFFF_0000 | 32'(cnt);
            claim_en   = 1'b1;
            claim_addr = 5'(31 - cnt % 31);
         end
         cyc();
         cnt++;
      end
      we       = 1'b0;
      claim_en = 1'b0;
   endtask

   // Every register must read zero and not busy on both ports
   task automatic checkAllClear(input string tag);
      for (int i = 0; i < 32; i++) begin
         rd_addr1 = 5'(i);
         rd_addr2 = 5'(31 - i);
         #1;
         checkVal($sformatf("%s_d1_r%0d", tag, i), 64'(rd_data1), 64'h0);
         checkVal($sformatf("%s_b1_r%0d", tag, i), 64'(rd_busy1), 64'h0);
         checkVal($sformatf("%s_d2_r%0d", tag, 31 - i), 64'(rd_data2), 64'h0);
         checkVal($sformatf("%s_b2_r%0d", tag, 31 - i), 64'(rd_busy2), 64'h0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      rd_addr1   = '0;
      rd_addr2   = '0;
      we         = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      claim_en   = 1'b0;
      claim_addr = '0;

      // Power-on reset and first INIT sweep
      #12;
      checkVal("rst_ready", 64'(ready), 64'h0);
      cyc();
      rst_n = 1'b1;
      checkVal("rel_ready", 64'(ready), 64'h0);
      waitReady(1'b0, n);
      checkVal("init1_len", 64'(n), 64'd31);
      checkAllClear("init1");

      // Basic write; r0 is write-protected
      cyc();
      we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
      cyc();
      wr_addr = 5'd0; wr_data = 32'h1234_5678;
      cyc();
      we = 1'b0;
      rd_addr1 = 5'd5; rd_addr2 = 5'd5;
      #1;
      checkVal("r5_p1", 64'(rd_data1), 64'hDEAD_BEEF);
      checkVal("r5_p2", 64'(rd_data2), 64'hDEAD_BEEF);
      rd_addr1 = 5'd0;
      #1;
      checkVal("r0_data", 64'(rd_data1), 64'h0);
      checkVal("r0_busy", 64'(rd_busy1), 64'h0);

      // Claim r7, then a write releases it
      cyc();
      claim_en = 1'b1; claim_addr = 5'd7;
      cyc();
      claim_en = 1'b0;
      rd_addr1 = 5'd7; rd_addr2 = 5'd7;
      #1;
      checkVal("r7_busy_p1", 64'(rd_busy1), 64'h1);
      checkVal("r7_busy_p2", 64'(rd_busy2), 64'h1);
      we = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_00A5;
      #1;
`ifdef REGFILE_BYPASS_EN
      checkVal("r7_wr_cyc_busy", 64'(rd_busy1), 64'h0);
      checkVal("r7_wr_cyc_data", 64'(rd_data1), 64'hA5);
`else
      checkVal("r7_wr_cyc_busy", 64'(rd_busy1), 64'h1);
      checkVal("r7_wr_cyc_data", 64'(rd_data1), 64'h0);
`endif
      cyc();
      we = 1'b0;
      #1;
      checkVal("r7_after_busy", 64'(rd_busy1), 64'h0);
      checkVal("r7_after_data", 64'(rd_data1), 64'hA5);

      // Claim and write r9 in the same cycle: claim wins, data still lands
      claim_en = 1'b1; claim_addr = 5'd9;
      we = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
      cyc();
      we = 1'b0; claim_en = 1'b0;
      rd_addr1 = 5'd9;
      #1;
      checkVal("r9_busy", 64'(rd_busy1), 64'h1);
      checkVal("r9_data", 64'(rd_data1), 64'h99);

      // Re-claiming a busy register keeps it busy; claiming r0 is ignored
      claim_en = 1'b1; claim_addr = 5'd9;
      cyc();
      claim_addr = 5'd0;
      cyc();
      claim_en = 1'b0;
      rd_addr2 = 5'd0;
      #1;
      checkVal("r9_reclaim", 64'(rd_busy1), 64'h1);
      checkVal("r0_claim", 64'(rd_busy2), 64'h0);

      // Write a non-busy r3, then the same-cycle read visibility case
      we = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0011;
      cyc();
      we = 1'b0;
      rd_addr1 = 5'd3; rd_addr2 = 5'd5;
      #1;
      checkVal("r3_first", 64'(rd_data1), 64'h11);
      checkVal("r3_nbusy", 64'(rd_busy1), 64'h0);
      checkVal("r5_indep", 64'(rd_data2), 64'hDEAD_BEEF);
      we = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0055;
      #1;
`ifdef REGFILE_BYPASS_EN
      checkVal("r3_wr_cyc", 64'(rd_data1), 64'h55);
`else
      checkVal("r3_wr_cyc", 64'(rd_data1), 64'h11);
`endif
      cyc();
      we = 1'b0;
      #1;
      checkVal("r3_next", 64'(rd_data1), 64'h55);

      // Reset in RUN with r4 written and busy
      cyc();
      we = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0044;
      cyc();
      we = 1'b0;
      claim_en = 1'b1; claim_addr = 5'd4;
      cyc();
      claim_en = 1'b0;
      rd_addr1 = 5'd5; rd_addr2 = 5'd4;
      #1;
      checkVal("r4_busy_pre", 64'(rd_busy2), 64'h1);
      checkVal("r4_data_pre", 64'(rd_data2), 64'h44);
      rst_n = 1'b0;
      #1;
      checkVal("run_rst_ready", 64'(ready), 64'h0);
      checkVal("run_rst_busy", 64'(rd_busy2), 64'h0);
      checkVal("run_rst_data", 64'(rd_data1), 64'h0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // Mid-INIT reset at cycle 10, with junk writes/claims during INIT
      for (int i = 0; i < 10; i++) begin
         we = 1'b1; wr_addr = 5'(i + 1); wr_data = 32'hCAFE_0000 | 32'(i);
         claim_en = 1'b1; claim_addr = 5'(i + 2);
         cyc();
      end
      we = 1'b0; claim_en = 1'b0;
      rd_addr1 = 5'd1;
      #1;
      checkVal("init2_ready", 64'(ready), 64'h0);
      checkVal("init2_rd0", 64'(rd_data1), 64'h0);
      checkVal("init2_busy0", 64'(rd_busy1), 64'h0);
      rst_n = 1'b0;
      #1;
      checkVal("init_rst_ready", 64'(ready), 64'h0);
      cyc();
      rst_n = 1'b1;
      waitReady(1'b1, n);
      checkVal("init3_len", 64'(n), 64'd31);
      checkAllClear("init3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
